// File: rtl/pipe_inport_debounce.sv
// Input-port front end: two-flop synchronisers, per-bit debounce counters and a sticky change mask.
// Build option: define INPORT_RISE_ONLY_EN so that only 0->1 debounced transitions set change_mask.
module pipe_inport_debounce #(
  parameter int unsigned W         = 4,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     sw0,
  input  logic [W-1:0]     sw1,
  input  logic             clr_changed,
  output logic [W-1:0]     in_port0,
  output logic [W-1:0]     in_port1,
  output logic [2*W-1:0]   change_mask,
  output logic             changed
);

  localparam int unsigned N     = 2 * W;
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     d;
  logic [N-1:0]     mismatch;
  logic [N-1:0]     flip;
  logic [N-1:0]     mask_set;
  logic [N-1:0]     mask_next;
  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_next [N];

  // Port 0 occupies the low half of every per-bit vector.
  assign raw      = {sw1, sw0};
  assign mismatch = s2 ^ d;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Saturating agreement counters: any cycle of agreement restarts the count.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = '0;
      if (mismatch[i]) begin
        if (cnt[i] == CNT_MAX) begin
          flip[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef INPORT_RISE_ONLY_EN
  assign mask_set = flip & ~d;
`else
  assign mask_set = flip;
`endif

  // A toggle on the clearing edge keeps its flag set.
  assign mask_next = (clr_changed ? '0 : change_mask) | mask_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      d           <= '0;
      change_mask <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      d           <= d ^ flip;
      change_mask <= mask_next;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign in_port0 = d[W-1:0];
  assign in_port1 = d[N-1:W];
  assign changed  = |change_mask;

endmodule

// File: tb/tb_pipe_inport_debounce.sv
// Directed bench for pipe_inport_debounce (DB_CYCLES=4) with a cycle-indexed expectation scoreboard.
module tb_pipe_inport_debounce;

  logic       clock;
  logic       reset;
  logic [3:0] sw0;
  logic [3:0] sw1;
  logic       clr_changed;
  logic [3:0] in_port0;
  logic [3:0] in_port1;
  logic [7:0] change_mask;
  logic       changed;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [7:0] m;
  } exp_t;

  exp_t sb[$];

  pipe_inport_debounce #(.W(4), .DB_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .sw0         (sw0),
    .sw1         (sw1),
    .clr_changed (clr_changed),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .change_mask (change_mask),
    .changed     (changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expectations are kept ordered by the edge number they refer to.
  function automatic void expect_at(int at, string name, logic [3:0] p0, logic [3:0] p1,
                                    logic [7:0] m);
    exp_t e;
    int   idx;
    e.at = at; e.name = name; e.p0 = p0; e.p1 = p1; e.m = m;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  task automatic at_cyc(int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: compares outputs shortly after each edge against entries due for that edge.
  always @(posedge clock) begin
    exp_t e;
    logic [16:0] act;
    logic [16:0] req;
    #2;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      total++;
      act = {in_port0, in_port1, change_mask, changed};
      req = {e.p0, e.p1, e.m, (e.m != 8'h00)};
      if (e.at < cyc) begin
        bad++;
        $display("FAIL %s: expectation for edge %0d missed (now edge %0d)", e.name, e.at, cyc);
      end else if (act !== req) begin
        bad++;
        $display("FAIL %s @edge %0d: got p0=%h p1=%h mask=%h changed=%b, want p0=%h p1=%h mask=%h changed=%b",
                 e.name, cyc, in_port0, in_port1, change_mask, changed,
                 e.p0, e.p1, e.m, (e.m != 8'h00));
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fall_mask;
`ifdef INPORT_RISE_ONLY_EN
    fall_mask = 8'h00;
`else
    fall_mask = 8'h01;
`endif
    reset = 1'b1; sw0 = 4'hF; sw1 = 4'hA; clr_changed = 1'b0;
    expect_at(1, "rst_e1", 4'h0, 4'h0, 8'h00);
    expect_at(2, "rst_e2", 4'h0, 4'h0, 8'h00);
    expect_at(3, "rst_e3", 4'h0, 4'h0, 8'h00);

    // Settle sw0=5 before the first edge after release: flip five edges later.
    at_cyc(3);
    reset = 1'b0; sw0 = 4'h5; sw1 = 4'h0;
    expect_at(4, "post_rst",  4'h0, 4'h0, 8'h00);
    expect_at(8, "db_hold",   4'h0, 4'h0, 8'h00);
    expect_at(9, "db_flip",   4'h5, 4'h0, 8'h05);

    // Three-cycle glitch on sw1[2] must be filtered.
    at_cyc(10);
    sw1 = 4'h4;
    expect_at(16, "glitch3_a", 4'h5, 4'h0, 8'h05);
    expect_at(20, "glitch3_b", 4'h5, 4'h0, 8'h05);
    at_cyc(13);
    sw1 = 4'h0;

    // Four-cycle pulse passes, then its trailing edge is debounced too.
    at_cyc(20);
    sw1 = 4'h4;
    expect_at(25, "pulse4_hold", 4'h5, 4'h0, 8'h05);
    expect_at(26, "pulse4_flip", 4'h5, 4'h4, 8'h45);
    expect_at(29, "pulse4_keep", 4'h5, 4'h4, 8'h45);
    expect_at(30, "pulse4_fall", 4'h5, 4'h0, 8'h45);
    at_cyc(24);
    sw1 = 4'h0;

    // sw0[1] completes debounce on the same edge as clr_changed.
    at_cyc(31);
    sw0 = 4'h7;
    expect_at(36, "pre_clr",      4'h5, 4'h0, 8'h45);
    expect_at(37, "clr_set_wins", 4'h7, 4'h0, 8'h02);
    expect_at(40, "mask_held",    4'h7, 4'h0, 8'h02);
    at_cyc(36);
    clr_changed = 1'b1;
    at_cyc(37);
    clr_changed = 1'b0;

    at_cyc(40);
    clr_changed = 1'b1;
    expect_at(41, "clr_alone", 4'h7, 4'h0, 8'h00);
    at_cyc(41);
    clr_changed = 1'b0;

    // Reset while sw0[3] has counted to 2; full latency needed again afterwards.
    at_cyc(42);
    sw0 = 4'hF;
    expect_at(47, "rst_mid",      4'h0, 4'h0, 8'h00);
    expect_at(52, "rst_relat",    4'h0, 4'h0, 8'h00);
    expect_at(53, "rst_relat_ok", 4'hF, 4'h0, 8'h0F);
    at_cyc(46);
    reset = 1'b1;
    at_cyc(47);
    reset = 1'b0;

    // Falling and rising edges of sw0[0] with respect to the mask.
    at_cyc(54);
    clr_changed = 1'b1;
    expect_at(55, "clr_before_fall", 4'hF, 4'h0, 8'h00);
    at_cyc(55);
    clr_changed = 1'b0;
    sw0 = 4'hE;
    expect_at(60, "fall_hold", 4'hF, 4'h0, 8'h00);
    expect_at(61, "fall_flip", 4'hE, 4'h0, fall_mask);
    at_cyc(62);
    sw0 = 4'hF;
    expect_at(67, "rise_hold", 4'hE, 4'h0, fall_mask);
    expect_at(68, "rise_flip", 4'hF, 4'h0, 8'h01);

    at_cyc(72);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: expectation for edge %0d never checked", e.name, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
